pipeline_latch: RTL and testbench
=================================

PIPELINE_LATCH -- requirements
Module: pipeline_latch

Interface
REQ-001 Parameter DATA_W, default 32: width of one field.
REQ-002 Parameter NUM_FIELDS, default 4: fields per stage (e.g. IR, PC, A, B); bus width W = NUM_FIELDS*DATA_W.
REQ-003 Parameter NEG_EDGE, default 1: 1 = all state captures on falling edge of clock; 0 = rising edge.
REQ-004 Parameter CNT_W, default 16: width of bubble counter.
REQ-005 clock  in  1  single clock; the only clock; reset is asynchronous and active-low.
REQ-006 reset  in  1  asynchronous, active-low; 0 clears all state immediately, independent of clock.
REQ-007 flush  in  1  synchronous kill of all held entries.
REQ-008 in_valid  in  1  upstream offers in_data.
REQ-009 in_data  in  W  upstream payload, field i at bits [i*DATA_W +: DATA_W].
REQ-010 in_ready  out  1  stage can accept this edge.
REQ-011 out_valid  out  1  out_data holds a live entry.
REQ-012 out_data  out  W  oldest held entry.
REQ-013 out_ready  in  1  downstream consumes this edge (0 = stall).
REQ-014 occupancy  out  2  entries held, 0..2.
REQ-015 bubble_count  out  CNT_W  saturating count of bubble edges.

Function
REQ-016 Storage: two W-bit entries, main and skid, plus a 2-bit occupancy state: EMPTY(0), ONE(1), FULL(2).
REQ-017 Every state element updates only on the active edge selected by NEG_EDGE.
REQ-018 accept = in_valid & in_ready; release = out_valid & out_ready; both sampled at the active edge.
REQ-019 in_ready = (occupancy != FULL); derived from registered state only, with no combinational path from out_ready.
REQ-020 out_valid = (occupancy != EMPTY); out_data = main when out_valid = 1, else all zeros (NOP bubble).
REQ-021 EMPTY: accept -> ONE, main <= in_data; otherwise remain in EMPTY.
REQ-022 ONE: accept & ~release -> FULL, skid <= in_data; release & ~accept -> EMPTY; accept & release -> ONE, main <= in_data; neither -> hold.
REQ-023 FULL: release -> ONE, main <= skid; otherwise hold; accept is impossible.
REQ-024 Latency: data accepted at edge k into EMPTY appears on out_data immediately after edge k, i.e. one edge.
REQ-025 Ordering is strict FIFO; no entry is dropped, duplicated or reordered except by flush or reset.
REQ-026 While out_valid = 1 and out_ready = 0, out_data is stable across edges.
REQ-027 flush = 1 at an edge overrides accept and release: occupancy <= EMPTY, main and skid <= 0; data offered in that cycle is discarded.
REQ-028 bubble_count increments by 1 at each edge where out_ready = 1 and out_valid = 0, saturates at 2^CNT_W-1, and is not cleared by flush.
REQ-029 Any field width is handled uniformly; no field has special semantics inside the block.

Reset
REQ-030 While reset = 0: occupancy = 0, out_valid = 0, out_data = 0, skid = 0, bubble_count = 0, in_ready = 1.
REQ-031 Reset assertion mid-transfer discards held entries with no edge required; the first active edge after reset deasserts behaves as EMPTY.

Verification
REQ-032 Pass-through (defaults): in_valid = 1, out_ready = 1, in_data = 0x...0001, 0x...0002, 0x...0003 on consecutive edges -> out_data shows each value one edge after acceptance, occupancy stays 1, in_ready stays 1.
REQ-033 Stall/skid: hold out_ready = 0, offer A = 0xA, then B = 0xB -> occupancy 1 then 2, in_ready = 0, out_data = 0xA stable; raise out_ready -> 0xA released, then 0xB, then occupancy 0.
REQ-034 Flush: in FULL holding 0xA and 0xB, assert flush with in_valid = 1 and in_data = 0xC -> next state occupancy 0, out_valid 0, out_data 0; 0xC never appears.
REQ-035 Simultaneous accept and release in ONE holding 0x5, offering 0x6 -> occupancy stays 1, out_data = 0x6.
REQ-036 Bubble counter: CNT_W = 2, out_ready = 1, in_valid = 0 for 5 edges -> bubble_count 1, 2, 3, 3, 3; flush leaves it at 3; reset returns it to 0.
REQ-037 Async reset: drop reset between edges while FULL -> outputs reach their REQ-030 values before the next edge; repeat the whole run with NEG_EDGE = 0 and NUM_FIELDS = 1, DATA_W = 8.

Source files
------------

// File: rtl/pipeline_latch.sv
// pipeline_latch: two-entry skid-buffered stage register with NOP bubbles.
// Ports: clock/reset(async, low), flush, in_*/out_* handshakes, occupancy, bubble_count.
module pipeline_latch #(
    parameter int DATA_W     = 32,
    parameter int NUM_FIELDS = 4,
    parameter int NEG_EDGE   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [NUM_FIELDS*DATA_W-1:0] in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [NUM_FIELDS*DATA_W-1:0] out_data,
    input  logic                         out_ready,
    output logic [1:0]                   occupancy,
    output logic [CNT_W-1:0]             bubble_count
);

    localparam int W = NUM_FIELDS * DATA_W;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       occ_q, occ_d;
    logic [W-1:0]     main_q, main_d;
    logic [W-1:0]     skid_q, skid_d;
    logic [CNT_W-1:0] bub_q, bub_d;

    logic accept;
    logic release_e;

    // Ready depends on held state only, so out_ready never
    // ripples back upstream within a cycle.
    assign in_ready  = (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign out_data  = out_valid ? main_q : '0;
    assign occupancy = occ_q;
    assign bubble_count = bub_q;

    assign accept    = in_valid & in_ready;
    assign release_e = out_valid & out_ready;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            occ_d  = EMPTY;
            main_d = '0;
            skid_d = '0;
        end else begin
            unique case (occ_q)
                EMPTY: begin
                    if (accept) begin
                        occ_d  = ONE;
                        main_d = in_data;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        accept && !release_e: begin
                            occ_d  = FULL;
                            skid_d = in_data;
                        end
                        release_e && !accept: begin
                            occ_d = EMPTY;
                        end
                        accept && release_e: begin
                            main_d = in_data;
                        end
                        default: ;
                    endcase
                end
                FULL: begin
                    if (release_e) begin
                        occ_d  = ONE;
                        main_d = skid_q;
                    end
                end
                default: occ_d = EMPTY;
            endcase
        end
    end

    // Bubble counter ignores flush; it saturates instead of wrapping.
    always_comb begin
        bub_d = bub_q;
        if (out_ready && !out_valid && (bub_q != {CNT_W{1'b1}}))
            bub_d = bub_q + CNT_W'(1);
    end

    if (NEG_EDGE != 0) begin : g_neg
        always_ff @(negedge clock or negedge reset) begin
            if (!reset) begin
                occ_q  <= EMPTY;
                main_q <= '0;
                skid_q <= '0;
                bub_q  <= '0;
            end else begin
                occ_q  <= occ_d;
                main_q <= main_d;
                skid_q <= skid_d;
                bub_q  <= bub_d;
            end
        end
    end else begin : g_pos
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                occ_q  <= EMPTY;
                main_q <= '0;
                skid_q <= '0;
                bub_q  <= '0;
            end else begin
                occ_q  <= occ_d;
                main_q <= main_d;
                skid_q <= skid_d;
                bub_q  <= bub_d;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_latch.sv
// tb_pipeline_latch: drives a falling-edge 4x32 instance and a rising-edge 1x8
// instance with identical stimulus against a queue scoreboard.
module tb_pipeline_latch;

    logic         clock;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_data;

    logic         rdy0, vld0;
    logic [127:0] dat0;
    logic [1:0]   occ0, bub0;
    logic         rdy1, vld1;
    logic [7:0]   dat1;
    logic [1:0]   occ1, bub1;

    logic [127:0] mq[$];
    int           mbub;
    int           n_cmp;
    int           n_err;

    pipeline_latch #(
        .DATA_W(32), .NUM_FIELDS(4), .NEG_EDGE(1), .CNT_W(2)
    ) u_dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy0),
        .out_valid(vld0), .out_data(dat0), .out_ready(out_ready),
        .occupancy(occ0), .bubble_count(bub0)
    );

    pipeline_latch #(
        .DATA_W(8), .NUM_FIELDS(1), .NEG_EDGE(0), .CNT_W(2)
    ) u_dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_data(in_data[7:0]), .in_ready(rdy1),
        .out_valid(vld1), .out_data(dat1), .out_ready(out_ready),
        .occupancy(occ1), .bubble_count(bub1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance the model, then let both instances see one active edge each.
    task automatic step();
        bit acc, rel, was_empty;
        acc = in_valid && (mq.size() < 2);
        rel = out_ready && (mq.size() > 0);
        was_empty = (mq.size() == 0);
        if (out_ready && was_empty && mbub < 3) mbub++;
        if (flush) mq.delete();
        else begin
            if (rel) void'(mq.pop_front());
            if (acc) mq.push_back(in_data);
        end
        if (!reset) begin
            mq.delete();
            mbub = 0;
        end
        @(negedge clock);
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 128'h1234;
        mq.delete(); mbub = 0;
        repeat (3) begin @(negedge clock); @(posedge clock); end
        #2;
        n_cmp++; if (vld0 !== 1'b0) begin n_err++; $display("FAIL reset_vld0 got %b want 0", vld0); end
        n_cmp++; if (dat0 !== 128'd0) begin n_err++; $display("FAIL reset_dat0 got %h want 0", dat0); end
        n_cmp++; if (occ0 !== 2'd0 || occ1 !== 2'd0) begin n_err++; $display("FAIL reset_occ got %0d/%0d want 0", occ0, occ1); end
        n_cmp++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_rdy got %b/%b want 1", rdy0, rdy1); end
        n_cmp++; if (bub0 !== 2'd0 || bub1 !== 2'd0) begin n_err++; $display("FAIL reset_bub got %0d/%0d want 0", bub0, bub1); end
        n_cmp++; if (vld1 !== 1'b0 || dat1 !== 8'd0) begin n_err++; $display("FAIL reset_out1 got %b/%h want 0/00", vld1, dat1); end
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_pass_through();
        in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
        for (int v = 1; v <= 3; v++) begin
            in_data = 128'(v);
            step();
            n_cmp++; if (dat0 !== 128'(v)) begin n_err++; $display("FAIL pass_dat0 got %h want %h", dat0, 128'(v)); end
            n_cmp++; if (dat1 !== 8'(v)) begin n_err++; $display("FAIL pass_dat1 got %h want %h", dat1, 8'(v)); end
            n_cmp++; if (occ0 !== 2'd1 || occ1 !== 2'd1) begin n_err++; $display("FAIL pass_occ got %0d/%0d want 1", occ0, occ1); end
            n_cmp++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_err++; $display("FAIL pass_rdy got %b/%b want 1", rdy0, rdy1); end
        end
        in_valid = 1'b0;
        step();
        n_cmp++; if (vld0 !== 1'b0 || vld1 !== 1'b0) begin n_err++; $display("FAIL pass_drain got %b/%b want 0", vld0, vld1); end
    endtask

    task automatic test_stall_skid();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'hA;
        step();
        n_cmp++; if (occ0 !== 2'd1 || occ1 !== 2'd1) begin n_err++; $display("FAIL skid_occ1 got %0d/%0d want 1", occ0, occ1); end
        in_data = 128'hB;
        step();
        n_cmp++; if (occ0 !== 2'd2 || occ1 !== 2'd2) begin n_err++; $display("FAIL skid_occ2 got %0d/%0d want 2", occ0, occ1); end
        n_cmp++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin n_err++; $display("FAIL skid_rdy got %b/%b want 0", rdy0, rdy1); end
        n_cmp++; if (dat0 !== 128'hA || dat1 !== 8'hA) begin n_err++; $display("FAIL skid_headA got %h/%h want a", dat0, dat1); end
        in_data = 128'hEE;
        step();
        n_cmp++; if (dat0 !== 128'hA || occ0 !== 2'd2) begin n_err++; $display("FAIL skid_stable got %h/%0d want a/2", dat0, occ0); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_cmp++; if (dat0 !== 128'hB || dat1 !== 8'hB) begin n_err++; $display("FAIL skid_headB got %h/%h want b", dat0, dat1); end
        n_cmp++; if (occ0 !== 2'd1 || occ1 !== 2'd1) begin n_err++; $display("FAIL skid_occ_after got %0d/%0d want 1", occ0, occ1); end
        step();
        n_cmp++; if (occ0 !== 2'd0 || occ1 !== 2'd0 || dat0 !== 128'd0) begin n_err++; $display("FAIL skid_empty got %0d/%0d/%h want 0", occ0, occ1, dat0); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'hA; step();
        in_data = 128'hB; step();
        flush = 1'b1; in_data = 128'hC;
        step();
        flush = 1'b0;
        n_cmp++; if (occ0 !== 2'd0 || occ1 !== 2'd0) begin n_err++; $display("FAIL flush_occ got %0d/%0d want 0", occ0, occ1); end
        n_cmp++; if (vld0 !== 1'b0 || vld1 !== 1'b0) begin n_err++; $display("FAIL flush_vld got %b/%b want 0", vld0, vld1); end
        n_cmp++; if (dat0 !== 128'd0 || dat1 !== 8'd0) begin n_err++; $display("FAIL flush_dat got %h/%h want 0", dat0, dat1); end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        n_cmp++; if (vld0 !== 1'b0 || dat0 !== 128'd0 || dat1 !== 8'd0) begin n_err++; $display("FAIL flush_no_c got %b/%h/%h want 0", vld0, dat0, dat1); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'h5; step();
        out_ready = 1'b1; in_data = 128'h6;
        step();
        n_cmp++; if (occ0 !== 2'd1 || occ1 !== 2'd1) begin n_err++; $display("FAIL simul_occ got %0d/%0d want 1", occ0, occ1); end
        n_cmp++; if (dat0 !== 128'h6 || dat1 !== 8'h6) begin n_err++; $display("FAIL simul_dat got %h/%h want 6", dat0, dat1); end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_bubble();
        int exp_b[5] = '{1, 2, 3, 3, 3};
        reset = 1'b0; step(); reset = 1'b1;
        n_cmp++; if (bub0 !== 2'd0 || bub1 !== 2'd0) begin n_err++; $display("FAIL bub_pre got %0d/%0d want 0", bub0, bub1); end
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (bub0 !== 2'(exp_b[i]) || bub1 !== 2'(exp_b[i])) begin
                n_err++; $display("FAIL bub_edge%0d got %0d/%0d want %0d", i, bub0, bub1, exp_b[i]);
            end
        end
        flush = 1'b1; step(); flush = 1'b0;
        n_cmp++; if (bub0 !== 2'd3 || bub1 !== 2'd3) begin n_err++; $display("FAIL bub_flush got %0d/%0d want 3", bub0, bub1); end
        reset = 1'b0; step(); reset = 1'b1;
        n_cmp++; if (bub0 !== 2'd0 || bub1 !== 2'd0) begin n_err++; $display("FAIL bub_reset got %0d/%0d want 0", bub0, bub1); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 128'h11; step();
        in_data = 128'h22; step();
        n_cmp++; if (occ0 !== 2'd2 || occ1 !== 2'd2) begin n_err++; $display("FAIL async_pre got %0d/%0d want 2", occ0, occ1); end
        #1 reset = 1'b0;
        mq.delete(); mbub = 0;
        #1;
        n_cmp++; if (occ0 !== 2'd0 || occ1 !== 2'd0) begin n_err++; $display("FAIL async_occ got %0d/%0d want 0", occ0, occ1); end
        n_cmp++; if (vld0 !== 1'b0 || vld1 !== 1'b0 || dat0 !== 128'd0 || dat1 !== 8'd0) begin n_err++; $display("FAIL async_out got %b/%b/%h/%h want 0", vld0, vld1, dat0, dat1); end
        n_cmp++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin n_err++; $display("FAIL async_rdy got %b/%b want 1", rdy0, rdy1); end
        @(negedge clock); @(posedge clock); #2;
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 128'h7;
        step();
        n_cmp++; if (occ0 !== 2'd1 || dat0 !== 128'h7 || occ1 !== 2'd1 || dat1 !== 8'h7) begin n_err++; $display("FAIL async_after got %0d/%h/%0d/%h want 1/7", occ0, dat0, occ1, dat1); end
        in_valid = 1'b0; step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp;
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
            exp = (mq.size() != 0) ? mq[0] : 128'd0;
            n_cmp++; if (dat0 !== exp) begin n_err++; $display("FAIL rand_dat0 step %0d got %h want %h", i, dat0, exp); end
            n_cmp++; if (dat1 !== exp[7:0]) begin n_err++; $display("FAIL rand_dat1 step %0d got %h want %h", i, dat1, exp[7:0]); end
            n_cmp++; if (occ0 !== 2'(mq.size()) || occ1 !== 2'(mq.size())) begin n_err++; $display("FAIL rand_occ step %0d got %0d/%0d want %0d", i, occ0, occ1, mq.size()); end
            n_cmp++; if (rdy0 !== (mq.size() < 2) || vld0 !== (mq.size() != 0)) begin n_err++; $display("FAIL rand_hs step %0d got %b/%b want %b/%b", i, rdy0, vld0, mq.size() < 2, mq.size() != 0); end
            n_cmp++; if (bub0 !== 2'(mbub) || bub1 !== 2'(mbub)) begin n_err++; $display("FAIL rand_bub step %0d got %0d/%0d want %0d", i, bub0, bub1, mbub); end
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_pass_through();
        test_stall_skid();
        test_flush();
        test_simultaneous();
        test_bubble();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
